// File: rtl/l2_cacheline_adaptor_pkg.sv
// Shared types and constants for the L2 cacheline to memory burst adaptor.
package l2_adaptor_types;

  localparam int BEATS    = 4;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    idle,
    read,
    write,
    done
  } adaptor_state_t;

endpackage

// File: rtl/l2_cacheline_adaptor.sv
// Bridges single-cycle cacheline transfers from the L2 cache to 4-beat
// burst transactions on physical memory. One transaction in flight at a time.
module l2_cacheline_adaptor
  import l2_adaptor_types::*;
#(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int NB    = LINE_W / BURST_W;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NB - 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

  adaptor_state_t    state;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] wr_line;
  logic [ADDR_W-1:0] addr_q;

  // Memory address and write beat come only from registers, never from inputs.
  assign address_o = addr_q;
  assign burst_o   = wr_line[cnt*BURST_W +: BURST_W];

  // Transaction FSM: acceptance, beat counting and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= idle;
      cnt     <= '0;
      resp_o  <= 1'b0;
      read_o  <= 1'b0;
      write_o <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state)
        idle: begin
          cnt    <= '0;
          resp_o <= 1'b0;
          // A simultaneous read and write is an L2 protocol error; the write wins.
          if (write_i) begin
            state   <= write;
            write_o <= 1'b1;
            addr_q  <= address_i & ADDR_MASK;
          end else if (read_i) begin
            state  <= read;
            read_o <= 1'b1;
            addr_q <= address_i & ADDR_MASK;
          end
        end
        read: begin
          if (resp_i) begin
            if (cnt == LAST_BEAT) begin
              state  <= done;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              cnt    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        write: begin
          if (resp_i) begin
            if (cnt == LAST_BEAT) begin
              state   <= done;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        done: begin
          // Held requests are not re-accepted here; idle samples them next.
          resp_o <= 1'b0;
          state  <= idle;
        end
        default: begin
          state   <= idle;
          cnt     <= '0;
          resp_o  <= 1'b0;
          read_o  <= 1'b0;
          write_o <= 1'b0;
        end
      endcase
    end
  end

  // Line storage: latch the writeback line on acceptance, assemble read beats by slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_line <= '0;
      line_o  <= '0;
    end else begin
      if (state == idle && write_i) begin
        wr_line <= line_i;
      end
      if (state == read && resp_i) begin
        line_o[cnt*BURST_W +: BURST_W] <= burst_i;
      end
    end
  end

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Directed testbench for l2_cacheline_adaptor.
module tb_l2_cacheline_adaptor;
  import l2_adaptor_types::*;

  logic         clk;
  logic         rst_n;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_chk;
  int n_fail;
  logic [255:0] last_line;

  l2_cacheline_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; line_i = '0; address_i = '0; read_i = 0; write_i = 0;
    burst_i = '0; resp_i = 0;
    tick(); tick();
    n_chk++; if (read_o !== 1'b0) begin n_fail++; $display("FAIL reset_read_o got %b exp 0", read_o); end
    n_chk++; if (write_o !== 1'b0) begin n_fail++; $display("FAIL reset_write_o got %b exp 0", write_o); end
    n_chk++; if (resp_o !== 1'b0) begin n_fail++; $display("FAIL reset_resp_o got %b exp 0", resp_o); end
    n_chk++; if (address_o !== 32'h0) begin n_fail++; $display("FAIL reset_address_o got %h exp 0", address_o); end
    n_chk++; if (burst_o !== 64'h0) begin n_fail++; $display("FAIL reset_burst_o got %h exp 0", burst_o); end
    n_chk++; if (line_o !== 256'h0) begin n_fail++; $display("FAIL reset_line_o got %h exp 0", line_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    logic [63:0] pat [4];
    logic [255:0] exp_line;
    pat[0] = 64'h1111_1111_1111_1111; pat[1] = 64'h2222_2222_2222_2222;
    pat[2] = 64'h3333_3333_3333_3333; pat[3] = 64'h4444_4444_4444_4444;
    exp_line = {pat[3], pat[2], pat[1], pat[0]};
    address_i = 32'h1234_567F; read_i = 1;
    tick(); // edge 0 accepts, now cycle 1
    n_chk++; if (read_o !== 1'b1) begin n_fail++; $display("FAIL read_req_c1 got %b exp 1", read_o); end
    n_chk++; if (address_o !== 32'h1234_5660) begin n_fail++; $display("FAIL read_addr got %h exp 12345660", address_o); end
    tick(); // cycle 2, memory starts beats
    n_chk++; if (read_o !== 1'b1 || resp_o !== 1'b0) begin n_fail++; $display("FAIL read_req_c2 got %b/%b exp 1/0", read_o, resp_o); end
    for (int b = 0; b < 4; b++) begin
      burst_i = pat[b]; resp_i = 1;
      tick(); // cycle 3+b
      if (b < 3) begin
        n_chk++; if (read_o !== 1'b1 || resp_o !== 1'b0) begin n_fail++; $display("FAIL read_beat%0d got read_o=%b resp_o=%b exp 1/0", b, read_o, resp_o); end
      end
    end
    resp_i = 0; burst_i = '0;
    // cycle 6: DONE
    n_chk++; if (resp_o !== 1'b1 || read_o !== 1'b0) begin n_fail++; $display("FAIL read_done got resp_o=%b read_o=%b exp 1/0", resp_o, read_o); end
    n_chk++; if (line_o !== exp_line) begin n_fail++; $display("FAIL read_line got %h exp %h", line_o, exp_line); end
    read_i = 0;
    tick();
    n_chk++; if (resp_o !== 1'b0) begin n_fail++; $display("FAIL read_resp_pulse got %b exp 0", resp_o); end
    last_line = exp_line;
  endtask

  task automatic test_write_gaps();
    logic [63:0] pat [4];
    pat[0] = 64'hAAAA_AAAA_AAAA_AAAA; pat[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    pat[2] = 64'hCCCC_CCCC_CCCC_CCCC; pat[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    line_i = {pat[3], pat[2], pat[1], pat[0]};
    address_i = 32'h0000_4444; write_i = 1;
    tick();
    line_i = '1; // latched copy must be used from here on
    n_chk++; if (write_o !== 1'b1) begin n_fail++; $display("FAIL wr_req got %b exp 1", write_o); end
    n_chk++; if (address_o !== 32'h0000_4440) begin n_fail++; $display("FAIL wr_addr got %h exp 00004440", address_o); end
    for (int b = 0; b < 4; b++) begin
      resp_i = 0;
      tick(); // gap cycle: beat held
      n_chk++; if (burst_o !== pat[b] || write_o !== 1'b1) begin n_fail++; $display("FAIL wr_gap%0d got burst_o=%h write_o=%b exp %h/1", b, burst_o, write_o, pat[b]); end
      resp_i = 1;
      tick();
      if (b < 3) begin
        n_chk++; if (burst_o !== pat[b+1] || write_o !== 1'b1 || resp_o !== 1'b0) begin n_fail++; $display("FAIL wr_beat%0d got burst_o=%h write_o=%b resp_o=%b exp %h/1/0", b, burst_o, write_o, resp_o, pat[b+1]); end
      end
    end
    resp_i = 0;
    n_chk++; if (resp_o !== 1'b1 || write_o !== 1'b0) begin n_fail++; $display("FAIL wr_done got resp_o=%b write_o=%b exp 1/0", resp_o, write_o); end
    n_chk++; if (line_o !== last_line) begin n_fail++; $display("FAIL wr_line_o_kept got %h exp %h", line_o, last_line); end
    write_i = 0;
    tick();
    n_chk++; if (resp_o !== 1'b0 || write_o !== 1'b0) begin n_fail++; $display("FAIL wr_idle got resp_o=%b write_o=%b exp 0/0", resp_o, write_o); end
  endtask

  task automatic test_both_requests();
    logic [63:0] pat [4];
    pat[0] = 64'h0101_0101_0101_0101; pat[1] = 64'h0202_0202_0202_0202;
    pat[2] = 64'h0303_0303_0303_0303; pat[3] = 64'h0404_0404_0404_0404;
    line_i = {pat[3], pat[2], pat[1], pat[0]};
    address_i = 32'h0000_0200; read_i = 1; write_i = 1;
    tick();
    n_chk++; if (write_o !== 1'b1 || read_o !== 1'b0) begin n_fail++; $display("FAIL both_accept got write_o=%b read_o=%b exp 1/0", write_o, read_o); end
    for (int b = 0; b < 4; b++) begin
      n_chk++; if (burst_o !== pat[b] || read_o !== 1'b0) begin n_fail++; $display("FAIL both_beat%0d got burst_o=%h read_o=%b exp %h/0", b, burst_o, read_o, pat[b]); end
      resp_i = 1;
      tick();
    end
    resp_i = 0;
    n_chk++; if (resp_o !== 1'b1 || read_o !== 1'b0) begin n_fail++; $display("FAIL both_done got resp_o=%b read_o=%b exp 1/0", resp_o, read_o); end
    n_chk++; if (line_o !== last_line) begin n_fail++; $display("FAIL both_line_o got %h exp %h", line_o, last_line); end
    read_i = 0; write_i = 0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    logic [63:0] pat [4];
    logic [255:0] exp_line;
    int resp_seen;
    pat[0] = 64'h5555_5555_5555_5555; pat[1] = 64'h6666_6666_6666_6666;
    pat[2] = 64'h7777_7777_7777_7777; pat[3] = 64'h8888_8888_8888_8888;
    exp_line = {pat[3], pat[2], pat[1], pat[0]};
    address_i = 32'h8000_0041; read_i = 1;
    tick();
    for (int b = 0; b < 2; b++) begin
      burst_i = 64'hDEAD_0000_0000_0000 | 64'(b); resp_i = 1;
      tick();
    end
    resp_i = 0; read_i = 0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (read_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_read_o got %b exp 0", read_o); end
    n_chk++; if (address_o !== 32'h0 || line_o !== 256'h0) begin n_fail++; $display("FAIL rst_mid_regs got addr=%h line=%h exp 0/0", address_o, line_o); end
    #1 rst_n = 1'b1;
    resp_seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (resp_o === 1'b1) resp_seen++;
    end
    n_chk++; if (resp_seen != 0) begin n_fail++; $display("FAIL rst_mid_no_resp got %0d exp 0", resp_seen); end
    address_i = 32'h8000_0041; read_i = 1;
    tick();
    n_chk++; if (read_o !== 1'b1 || address_o !== 32'h8000_0040) begin n_fail++; $display("FAIL rst_new_req got read_o=%b addr=%h exp 1/80000040", read_o, address_o); end
    for (int b = 0; b < 4; b++) begin
      burst_i = pat[b]; resp_i = 1;
      tick();
    end
    resp_i = 0;
    n_chk++; if (resp_o !== 1'b1 || line_o !== exp_line) begin n_fail++; $display("FAIL rst_new_read got resp_o=%b line=%h exp 1/%h", resp_o, line_o, exp_line); end
    read_i = 0;
    tick();
    last_line = exp_line;
  endtask

  task automatic test_back_to_back();
    logic [63:0] pat [4];
    logic [255:0] exp1;
    logic [255:0] exp2;
    pat[0] = 64'h0123_4567_89AB_CDEF; pat[1] = 64'hFEDC_BA98_7654_3210;
    pat[2] = 64'h0F0F_0F0F_F0F0_F0F0; pat[3] = 64'h1357_9BDF_2468_ACE0;
    exp1 = {pat[3], pat[2], pat[1], pat[0]};
    exp2 = {pat[0], pat[1], pat[2], pat[3]};
    // spurious memory strobes while idle
    read_i = 0; burst_i = 64'hBAD0_BAD0_BAD0_BAD0; resp_i = 1;
    tick(); tick();
    resp_i = 0;
    n_chk++; if (line_o !== last_line || resp_o !== 1'b0) begin n_fail++; $display("FAIL idle_resp_i got line=%h resp_o=%b exp %h/0", line_o, resp_o, last_line); end
    address_i = 32'hABCD_0023; read_i = 1;
    tick();
    n_chk++; if (address_o !== 32'hABCD_0020 || read_o !== 1'b1) begin n_fail++; $display("FAIL b2b_first got addr=%h read_o=%b exp abcd0020/1", address_o, read_o); end
    for (int b = 0; b < 4; b++) begin
      burst_i = pat[b]; resp_i = 1;
      tick();
    end
    resp_i = 0;
    n_chk++; if (resp_o !== 1'b1 || line_o !== exp1) begin n_fail++; $display("FAIL b2b_done1 got resp_o=%b line=%h exp 1/%h", resp_o, line_o, exp1); end
    address_i = 32'h0000_F0FF; // read_i stays high through done
    tick();
    n_chk++; if (read_o !== 1'b0 || resp_o !== 1'b0) begin n_fail++; $display("FAIL b2b_dead got read_o=%b resp_o=%b exp 0/0", read_o, resp_o); end
    tick();
    n_chk++; if (read_o !== 1'b1 || address_o !== 32'h0000_F0E0) begin n_fail++; $display("FAIL b2b_second got read_o=%b addr=%h exp 1/0000f0e0", read_o, address_o); end
    for (int b = 0; b < 4; b++) begin
      burst_i = pat[3-b]; resp_i = 1;
      tick();
      if (b < 3) begin
        n_chk++; if (resp_o !== 1'b0) begin n_fail++; $display("FAIL b2b_beat%0d resp_o got %b exp 0", b, resp_o); end
      end
    end
    resp_i = 0;
    n_chk++; if (resp_o !== 1'b1 || line_o !== exp2) begin n_fail++; $display("FAIL b2b_done2 got resp_o=%b line=%h exp 1/%h", resp_o, line_o, exp2); end
    read_i = 0;
    tick();
    n_chk++; if (resp_o !== 1'b0 || read_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end got resp_o=%b read_o=%b exp 0/0", resp_o, read_o); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    last_line = '0;
    test_reset();
    test_read();
    test_write_gaps();
    test_both_requests();
    test_reset_mid_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
